// File: rtl/usb_fs_transmitter.sv
// Full-speed USB packet transmitter: byte stream in, SYNC + NRZI/bit-stuffed data + EOP out.
// Line outputs only change on the clock edge that starts a new bit time.
module usb_fs_transmitter #(
  parameter int unsigned CLOCKS_PER_BIT = 4,
  parameter int unsigned STUFF_LIMIT    = 6
) (
  input  logic       clock48,
  input  logic       reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       usb_tx_dp,
  output logic       usb_tx_dn,
  output logic       usb_tx_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_underrun
);

  localparam int unsigned PHASE_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CLOCKS_PER_BIT - 1);
  localparam logic [2:0] ONES_MAX  = 3'(STUFF_LIMIT);
  localparam logic [7:0] SYNC_BYTE = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP_SE0,
    ST_EOP_J
  } state_t;

  state_t             state_q, state_n;
  logic [PHASE_W-1:0] phase_q, phase_n;
  logic [2:0]         bit_idx_q, bit_idx_n;
  logic [7:0]         data_q, data_n;
  logic               last_q, last_n;
  logic [2:0]         ones_q, ones_n;
  logic               level_q, level_n;
  logic               dp_q, dp_n;
  logic               dn_q, dn_n;
  logic               oe_q, oe_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;
  logic               ready_q, ready_n;

  logic               bit_end;
  logic               stuff_pending;
  logic               send_bit;
  logic               bit_val;
  logic               go_eop;
  logic               underrun_c;

  assign bit_end       = (phase_q == PHASE_LAST);
  assign stuff_pending = (ones_q >= ONES_MAX);

  // Next-state, line coding and handshake decode
  always_comb begin
    state_n    = state_q;
    phase_n    = bit_end ? '0 : phase_q + PHASE_W'(1);
    bit_idx_n  = bit_idx_q;
    data_n     = data_q;
    last_n     = last_q;
    ones_n     = ones_q;
    level_n    = level_q;
    dp_n       = dp_q;
    dn_n       = dn_q;
    oe_n       = oe_q;
    send_bit   = 1'b0;
    bit_val    = 1'b0;
    go_eop     = 1'b0;
    underrun_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        phase_n = '0;
        if (tx_valid) begin
          data_n    = tx_data;
          last_n    = tx_last;
          state_n   = ST_SYNC;
          bit_idx_n = 3'd0;
          ones_n    = 3'd0;
          level_n   = 1'b1;
          oe_n      = 1'b1;
          send_bit  = 1'b1;
          bit_val   = SYNC_BYTE[0];
        end
      end

      ST_SYNC: begin
        if (bit_end) begin
          send_bit = 1'b1;
          if (bit_idx_q == 3'd7) begin
            state_n   = ST_DATA;
            bit_idx_n = 3'd0;
            bit_val   = data_q[0];
          end else begin
            bit_idx_n = bit_idx_q + 3'd1;
            bit_val   = SYNC_BYTE[bit_idx_n];
          end
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          if (stuff_pending) begin
            // Stuffed zero: forced transition, bit index holds
            send_bit = 1'b1;
            bit_val  = 1'b0;
          end else if (bit_idx_q != 3'd7) begin
            bit_idx_n = bit_idx_q + 3'd1;
            send_bit  = 1'b1;
            bit_val   = data_q[bit_idx_n];
          end else if (last_q) begin
            go_eop = 1'b1;
          end else if (tx_valid) begin
            data_n    = tx_data;
            last_n    = tx_last;
            bit_idx_n = 3'd0;
            send_bit  = 1'b1;
            bit_val   = tx_data[0];
          end else begin
            underrun_c = 1'b1;
            go_eop     = 1'b1;
          end
        end
      end

      ST_EOP_SE0: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd1) begin
            state_n = ST_EOP_J;
            level_n = 1'b1;
            dp_n    = 1'b1;
            dn_n    = 1'b0;
          end else begin
            bit_idx_n = 3'd1;
          end
        end
      end

      ST_EOP_J: begin
        if (bit_end) begin
          state_n = ST_IDLE;
          oe_n    = 1'b0;
          dp_n    = 1'b1;
          dn_n    = 1'b0;
        end
      end

      default: begin
        state_n = ST_IDLE;
        oe_n    = 1'b0;
        dp_n    = 1'b1;
        dn_n    = 1'b0;
      end
    endcase

    if (go_eop) begin
      state_n   = ST_EOP_SE0;
      bit_idx_n = 3'd0;
      dp_n      = 1'b0;
      dn_n      = 1'b0;
    end

    // NRZI: a zero toggles the level, a one holds it and extends the run
    if (send_bit) begin
      if (!bit_val) level_n = ~level_n;
      if (!bit_val)                ones_n = 3'd0;
      else if (ones_n < ONES_MAX)  ones_n = ones_n + 3'd1;
      dp_n = level_n;
      dn_n = ~level_n;
    end

    busy_n  = (state_n != ST_IDLE);
    done_n  = (state_n == ST_EOP_J) && (phase_n == PHASE_LAST);
    ready_n = (state_n == ST_IDLE) ||
              ((state_n == ST_DATA) && (phase_n == PHASE_LAST) && (bit_idx_n == 3'd7) &&
               (ones_n < ONES_MAX) && !last_n);
  end

  always_ff @(posedge clock48 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      bit_idx_q <= 3'd0;
      data_q    <= 8'h00;
      last_q    <= 1'b0;
      ones_q    <= 3'd0;
      level_q   <= 1'b1;
      dp_q      <= 1'b1;
      dn_q      <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_n;
      phase_q   <= phase_n;
      bit_idx_q <= bit_idx_n;
      data_q    <= data_n;
      last_q    <= last_n;
      ones_q    <= ones_n;
      level_q   <= level_n;
      dp_q      <= dp_n;
      dn_q      <= dn_n;
      oe_q      <= oe_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      ready_q   <= ready_n;
    end
  end

  assign tx_ready    = ready_q;
  assign usb_tx_dp   = dp_q;
  assign usb_tx_dn   = dn_q;
  assign usb_tx_oe   = oe_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_underrun = underrun_c;

endmodule

// File: tb/tb_usb_fs_transmitter.sv
// Bench for usb_fs_transmitter: expected line symbols queued per packet, checked every cycle.
`timescale 1ns/1ps
module tb_usb_fs_transmitter;

  logic       clock48 = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;
  logic       tx_ready, usb_tx_dp, usb_tx_dn, usb_tx_oe, tx_busy, tx_done, tx_underrun;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  localparam logic [1:0] SYM_J   = 2'b10;
  localparam logic [1:0] SYM_K   = 2'b01;
  localparam logic [1:0] SYM_SE0 = 2'b00;

  logic [1:0] exp_q[$];
  logic       m_level;
  int         m_ones;

  usb_fs_transmitter dut (
    .clock48     (clock48),
    .reset_n     (reset_n),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_last     (tx_last),
    .tx_ready    (tx_ready),
    .usb_tx_dp   (usb_tx_dp),
    .usb_tx_dn   (usb_tx_dn),
    .usb_tx_oe   (usb_tx_oe),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_underrun (tx_underrun)
  );

  always #10 clock48 = ~clock48;
  always @(posedge clock48) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference line model: NRZI with a stuffed zero after six consecutive ones
  task automatic model_bit(input logic b);
    if (!b) m_level = ~m_level;
    m_ones = b ? m_ones + 1 : 0;
    exp_q.push_back(m_level ? SYM_J : SYM_K);
    if (m_ones == 6) begin
      m_level = ~m_level;
      m_ones  = 0;
      exp_q.push_back(m_level ? SYM_J : SYM_K);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) model_bit(b[i]);
  endtask

  task automatic model_start();
    m_level = 1'b1;
    m_ones  = 0;
    model_byte(8'h80);
  endtask

  task automatic model_eop();
    exp_q.push_back(SYM_SE0);
    exp_q.push_back(SYM_SE0);
    exp_q.push_back(SYM_J);
  endtask

  // Offer one byte from a negedge; returns the cycle count seen just after the accept edge
  task automatic send_byte(input logic [7:0] b, input logic last, output int acc);
    int t;
    tx_valid = 1'b1;
    tx_data  = b;
    tx_last  = last;
    t = 0;
    while (!tx_ready && t < 400) begin
      @(negedge clock48);
      t++;
    end
    n_vec++;
    if (!tx_ready) begin
      $display("FAIL handshake byte %h: tx_ready=%b, required 1 within 400 cycles", b, tx_ready);
      n_fail++;
      tx_valid = 1'b0;
      acc = -1;
    end else begin
      @(negedge clock48);
      acc = cyc;
      tx_valid = 1'b0;
    end
  endtask

  // Pops nbits expected symbols and checks each held for four cycles
  task automatic monitor(input int nbits, output int start_c, output int oe_c,
                         output int under_c, output int under_n, output int ready_c);
    int t;
    logic [1:0] sym;
    logic exp_done;
    start_c = -1; oe_c = 0; under_c = -1; under_n = 0; ready_c = 0;
    t = 0;
    while (!usb_tx_oe && t < 400) begin
      @(negedge clock48);
      t++;
    end
    n_vec++;
    if (!usb_tx_oe) begin
      $display("FAIL oe_start: oe=%b, required 1 within 400 cycles", usb_tx_oe);
      n_fail++;
      for (int i = 0; i < nbits && exp_q.size() > 0; i++) void'(exp_q.pop_front());
      return;
    end
    start_c = cyc;
    for (int b = 0; b < nbits; b++) begin
      sym = (exp_q.size() > 0) ? exp_q.pop_front() : SYM_J;
      for (int p = 0; p < 4; p++) begin
        n_vec++;
        if ({usb_tx_dp, usb_tx_dn} !== sym || usb_tx_oe !== 1'b1) begin
          $display("FAIL line bit %0d phase %0d: dp/dn/oe=%b%b%b, required %b%b1",
                   b, p, usb_tx_dp, usb_tx_dn, usb_tx_oe, sym[1], sym[0]);
          n_fail++;
        end
        exp_done = (b == nbits - 1) && (p == 3);
        n_vec++;
        if (tx_done !== exp_done) begin
          $display("FAIL tx_done bit %0d phase %0d: got %b, required %b", b, p, tx_done, exp_done);
          n_fail++;
        end
        n_vec++;
        if (tx_busy !== 1'b1) begin
          $display("FAIL tx_busy bit %0d phase %0d: got %b, required 1", b, p, tx_busy);
          n_fail++;
        end
        if (usb_tx_oe) oe_c++;
        if (tx_underrun) begin
          under_c = cyc;
          under_n++;
        end
        if (tx_ready) ready_c++;
        @(negedge clock48);
      end
    end
    t = 0;
    while (usb_tx_oe && t < 20) begin
      oe_c++;
      @(negedge clock48);
      t++;
    end
    n_vec++;
    if ({usb_tx_oe, usb_tx_dp, usb_tx_dn, tx_busy, tx_done} !== 5'b01000) begin
      $display("FAIL post_eop oe/dp/dn/busy/done: got %b%b%b%b%b, required 01000",
               usb_tx_oe, usb_tx_dp, usb_tx_dn, tx_busy, tx_done);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock48);
    n_vec++;
    if ({usb_tx_oe, usb_tx_dp, usb_tx_dn, tx_busy, tx_done, tx_underrun} !== 6'b010000) begin
      $display("FAIL reset_outputs oe/dp/dn/busy/done/underrun: got %b%b%b%b%b%b, required 010000",
               usb_tx_oe, usb_tx_dp, usb_tx_dn, tx_busy, tx_done, tx_underrun);
      n_fail++;
    end
    reset_n = 1'b1;
    @(negedge clock48);
    n_vec++;
    if (tx_ready !== 1'b1) begin
      $display("FAIL reset_ready: got %b, required 1", tx_ready);
      n_fail++;
    end
  endtask

  task automatic test_ack();
    logic [1:0] seq [19];
    int acc, s, oe_c, uc, un, rc;
    seq = '{SYM_K, SYM_J, SYM_K, SYM_J, SYM_K, SYM_J, SYM_K, SYM_K,
            SYM_J, SYM_J, SYM_K, SYM_J, SYM_J, SYM_K, SYM_K, SYM_K,
            SYM_SE0, SYM_SE0, SYM_J};
    for (int i = 0; i < 19; i++) exp_q.push_back(seq[i]);
    fork
      send_byte(8'hD2, 1'b1, acc);
      monitor(19, s, oe_c, uc, un, rc);
    join
    n_vec++;
    if (oe_c !== 76) begin
      $display("FAIL ack_oe_cycles: got %0d, required 76", oe_c);
      n_fail++;
    end
    n_vec++;
    if (rc !== 0) begin
      $display("FAIL ack_ready_during_packet: got %0d high cycles, required 0", rc);
      n_fail++;
    end
    n_vec++;
    if (un !== 0) begin
      $display("FAIL ack_underrun: got %0d pulses, required 0", un);
      n_fail++;
    end
  endtask

  task automatic test_stuffing();
    int a0, a1, s, oe_c, uc, un, rc, n;
    model_start();
    model_byte(8'hFF);
    model_byte(8'hFF);
    model_eop();
    n = exp_q.size();
    fork
      begin
        send_byte(8'hFF, 1'b0, a0);
        send_byte(8'hFF, 1'b1, a1);
      end
      monitor(n, s, oe_c, uc, un, rc);
    join
    n_vec++;
    if (oe_c !== 116) begin
      $display("FAIL stuff_ff_oe_cycles: got %0d, required 116", oe_c);
      n_fail++;
    end
  endtask

  task automatic test_stuff_eop();
    logic [7:0] bytes [2];
    int acc, s, oe_c, uc, un, rc, n;
    bytes = '{8'h3F, 8'hFC};
    for (int k = 0; k < 2; k++) begin
      model_start();
      model_byte(bytes[k]);
      model_eop();
      n = exp_q.size();
      fork
        send_byte(bytes[k], 1'b1, acc);
        monitor(n, s, oe_c, uc, un, rc);
      join
      n_vec++;
      if (oe_c !== 80) begin
        $display("FAIL stuff_eop_%h_oe_cycles: got %0d, required 80", bytes[k], oe_c);
        n_fail++;
      end
    end
  endtask

  task automatic test_underrun();
    int acc, s, oe_c, uc, un, rc, n;
    model_start();
    model_byte(8'h69);
    model_eop();
    n = exp_q.size();
    fork
      send_byte(8'h69, 1'b0, acc);
      monitor(n, s, oe_c, uc, un, rc);
    join
    n_vec++;
    if (un !== 1 || uc !== s + 63) begin
      $display("FAIL underrun_pulse: got %0d pulses at offset %0d, required 1 at offset 63",
               un, uc - s);
      n_fail++;
    end
    n_vec++;
    if (oe_c !== 76) begin
      $display("FAIL underrun_oe_cycles: got %0d, required 76", oe_c);
      n_fail++;
    end
  endtask

  task automatic test_multi_byte();
    int a0, a1, a2, s, oe_c, uc, un, rc, n;
    model_start();
    model_byte(8'hC3);
    model_byte(8'h00);
    model_byte(8'h01);
    model_eop();
    n = exp_q.size();
    fork
      begin
        send_byte(8'hC3, 1'b0, a0);
        send_byte(8'h00, 1'b0, a1);
        send_byte(8'h01, 1'b1, a2);
      end
      monitor(n, s, oe_c, uc, un, rc);
    join
    n_vec++;
    if (a1 - a0 !== 64 || a2 - a1 !== 32) begin
      $display("FAIL multi_handshake_spacing: got %0d/%0d, required 64/32", a1 - a0, a2 - a1);
      n_fail++;
    end
    n_vec++;
    if (oe_c !== 140) begin
      $display("FAIL multi_oe_cycles: got %0d, required 140", oe_c);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    int a0, a1, s0, s1, oe0, oe1, uc, un, rc, n0, n1;
    model_start();
    model_byte(8'hD2);
    model_eop();
    n0 = exp_q.size();
    model_start();
    model_byte(8'h5A);
    model_eop();
    n1 = exp_q.size() - n0;
    fork
      begin
        send_byte(8'hD2, 1'b1, a0);
        send_byte(8'h5A, 1'b1, a1);
      end
      begin
        monitor(n0, s0, oe0, uc, un, rc);
        monitor(n1, s1, oe1, uc, un, rc);
      end
    join
    n_vec++;
    if (a1 - a0 !== 77) begin
      $display("FAIL back_to_back_accept_gap: got %0d, required 77", a1 - a0);
      n_fail++;
    end
    n_vec++;
    if (oe1 !== 76) begin
      $display("FAIL back_to_back_oe_cycles: got %0d, required 76", oe1);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_packet();
    int acc;
    send_byte(8'hA5, 1'b1, acc);
    repeat (40) @(negedge clock48);
    n_vec++;
    if (usb_tx_oe !== 1'b1) begin
      $display("FAIL mid_packet_oe_before_reset: got %b, required 1", usb_tx_oe);
      n_fail++;
    end
    #3 reset_n = 1'b0;
    #1;
    n_vec++;
    if ({usb_tx_oe, usb_tx_dp, usb_tx_dn, tx_busy} !== 4'b0100) begin
      $display("FAIL async_reset oe/dp/dn/busy: got %b%b%b%b, required 0100",
               usb_tx_oe, usb_tx_dp, usb_tx_dn, tx_busy);
      n_fail++;
    end
    @(negedge clock48);
    reset_n = 1'b1;
    @(negedge clock48);
    test_ack();
  endtask

  initial begin
    test_reset();
    test_ack();
    test_stuffing();
    test_stuff_eop();
    test_underrun();
    test_multi_byte();
    test_back_to_back();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
